// File: rtl/lynx_memctl.sv
// lynx_memctl: shares one byte-wide SRAM between the Z80 and the video fetcher; CPU writes can broadcast to several banks.
// Latency: CPU read 1..VSHARE+1 slots; write popcount(mask) CPU slots plus interleaved video; video <= VSHARE+1 slots.
// Backpressure: waitn is held low while a CPU read/write is outstanding; a newer video request overwrites a pending one.
module lynx_memctl #(
    parameter int          BANKS    = 4,
    parameter int          RAW      = 21,
    parameter int          VSHARE   = 2,
    parameter logic [7:0]  BANKPORT = 8'h7F,
    localparam int         BW       = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           ce,
    input  logic           mreq,
    input  logic           iorq,
    input  logic           wr,
    input  logic [15:0]    a,
    input  logic [7:0]     dout,     // Z80 write data ("do" is a reserved word)
    output logic [7:0]     di,
    output logic           waitn,
    input  logic           vidReq,
    input  logic [BW-1:0]  vidBank,
    input  logic [15:0]    vidA,
    output logic [7:0]     vidD,
    output logic           vidValid,
    output logic           ramWe,
    output logic           ramDe,
    output logic [7:0]     ramDo,
    input  logic [7:0]     ramDi,
    output logic [RAW-1:0] ramA
);
    localparam int            SW        = (VSHARE > 1) ? $clog2(VSHARE) : 1;
    localparam logic [3:0]    BMASK     = 4'((1 << BANKS) - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(VSHARE - 1);

    typedef enum logic [1:0] {IDLE, RD, WR, HOLD} state_t;
    typedef enum logic [1:0] {OP_NONE, OP_VID, OP_RD, OP_WR} op_t;

    state_t          state, state_nx;
    op_t             cur_op, open_op;
    logic [BW-1:0]   cur_bank, wr_bank;
    logic [3:0]      wmask, wl, wl_nx, wl_after;
    logic [BW-1:0]   rbank, cpu_rbank;
    logic [15:0]     cpu_a;
    logic [7:0]      cpu_d;
    logic            mreq_q, mreq_fall, bank_wr;
    logic [SW-1:0]   slot;
    logic            vid_pend;
    logic [BW-1:0]   vid_bank_p;
    logic [15:0]     vid_a_p;
    logic [RAW-1:0]  open_a;

    // FSM next state, wait generation and the choice of what the slot opening at this ce does
    always_comb begin
        mreq_fall = mreq_q && !mreq;
        bank_wr   = !iorq && !wr && (a[7:0] == BANKPORT);
        // the write slot closing at this ce retires its bank from the latched mask
        wl_after  = wl;
        if (cur_op == OP_WR) wl_after = wl & ~(4'b0001 << cur_bank);
        wr_bank = '0;
        for (int i = 3; i >= 0; i--) begin
            if (wl_after[i]) wr_bank = BW'(i);
        end
        state_nx = state;
        wl_nx    = wl;
        case (state)
            IDLE: if (mreq_fall) begin
                if (wr) state_nx = RD;
                else if (wmask != 4'd0) begin
                    state_nx = WR;
                    wl_nx    = wmask;
                end else state_nx = HOLD;
            end
            RD:   if (ce && cur_op == OP_RD) state_nx = HOLD;
            WR:   if (ce) begin
                wl_nx = wl_after;
                if (wl_after == 4'd0) state_nx = HOLD;
            end
            HOLD: if (mreq) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        waitn = !((state == RD) || (state == WR) ||
                  ((state == IDLE) && mreq_fall && (wr || (wmask != 4'd0))));
        // video owns slot 0 only when it has something pending; otherwise the CPU may take it
        open_op = OP_NONE;
        if (ce) begin
            if (slot == '0 && vid_pend)                    open_op = OP_VID;
            else if (state == RD && cur_op != OP_RD)       open_op = OP_RD;
            else if (state == WR && wl_after != 4'd0)      open_op = OP_WR;
        end
        open_a = '0;
        case (open_op)
            OP_VID: begin open_a[15:0] = vid_a_p; open_a[16 +: BW] = vid_bank_p; end
            OP_RD:  begin open_a[15:0] = cpu_a;   open_a[16 +: BW] = cpu_rbank;  end
            OP_WR:  begin open_a[15:0] = cpu_a;   open_a[16 +: BW] = wr_bank;    end
            default: ;
        endcase
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // CPU side: bank register, access latch, write-mask progress and read data
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mreq_q    <= 1'b0;
            wmask     <= '0;
            rbank     <= '0;
            wl        <= '0;
            cpu_a     <= '0;
            cpu_d     <= '0;
            cpu_rbank <= '0;
            di        <= 8'hFF;
        end else begin
            mreq_q <= mreq;
            wl     <= wl_nx;
            if (bank_wr) begin
                wmask <= dout[3:0] & BMASK;
                rbank <= dout[4 +: BW];
            end
            if (state == IDLE && mreq_fall) begin
                cpu_a     <= a;
                cpu_d     <= dout;
                cpu_rbank <= rbank;
            end
            if (ce && cur_op == OP_RD) di <= ramDi;
        end
    end

    // slot sequencing and the video request / response path
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot       <= '0;
            cur_op     <= OP_NONE;
            cur_bank   <= '0;
            vid_pend   <= 1'b0;
            vid_bank_p <= '0;
            vid_a_p    <= '0;
            vidD       <= '0;
            vidValid   <= 1'b0;
        end else begin
            vidValid <= ce && (cur_op == OP_VID);
            if (ce && cur_op == OP_VID) vidD <= ramDi;
            // a request arriving while the old one is being served becomes the new pending one
            if (vidReq) begin
                vid_pend   <= 1'b1;
                vid_bank_p <= vidBank;
                vid_a_p    <= vidA;
            end else if (open_op == OP_VID) begin
                vid_pend <= 1'b0;
            end
            if (ce) begin
                slot     <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
                cur_op   <= open_op;
                cur_bank <= wr_bank;
            end
        end
    end

    // SRAM pins change only at the ce that opens a slot; idle slots keep the last address
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ramWe <= 1'b1;
            ramDe <= 1'b0;
            ramDo <= '0;
            ramA  <= '0;
        end else if (ce) begin
            if (open_op == OP_NONE) begin
                ramWe <= 1'b1;
                ramDe <= 1'b0;
            end else begin
                ramA  <= open_a;
                ramWe <= (open_op != OP_WR);
                ramDe <= (open_op == OP_WR);
                if (open_op == OP_WR) ramDo <= cpu_d;
            end
        end
    end
endmodule
